// File: rtl/timer_ctrl_pkg.sv
// rtl/timer_ctrl_pkg.sv - shared state encodings and default width for the interval-timer controller
package timer_ctrl_pkg;

    localparam int WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOAD = 2'b01,
        S_RUN  = 2'b10,
        S_DONE = 2'b11
    } state_e;

endpackage

// File: rtl/timer_ctrl_4b_if.sv
// rtl/timer_ctrl_4b_if.sv - control/status bundle between timer controller, its user and the up-counter (optional pause: TIMER_CTRL_PAUSE_EN)
interface timer_ctrl_4b_if
    import timer_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic             start;
    logic             stop;
    logic             auto_rl;
    logic [WIDTH-1:0] period;
    logic             tcount;
`ifdef TIMER_CTRL_PAUSE_EN
    logic             pause;
`endif
    logic             ld;
    logic             cnt;
    logic [WIDTH-1:0] load_val;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] laps;

`ifdef TIMER_CTRL_PAUSE_EN
    modport master (output start, stop, auto_rl, period, tcount, pause,
                    input  ld, cnt, load_val, busy, done, laps);
    modport slave  (input  start, stop, auto_rl, period, tcount, pause,
                    output ld, cnt, load_val, busy, done, laps);
`else
    modport master (output start, stop, auto_rl, period, tcount,
                    input  ld, cnt, load_val, busy, done, laps);
    modport slave  (input  start, stop, auto_rl, period, tcount,
                    output ld, cnt, load_val, busy, done, laps);
`endif
endinterface

// File: rtl/timer_ctrl_fsm.sv
// rtl/timer_ctrl_fsm.sv - IDLE/LOAD/RUN/DONE sequencer driving counter ld/cnt (optional pause: TIMER_CTRL_PAUSE_EN)
module timer_ctrl_fsm
    import timer_ctrl_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic stop_i,
    input  logic auto_rl_i,
    input  logic tcount_i,
`ifdef TIMER_CTRL_PAUSE_EN
    input  logic pause_i,
`endif
    output logic ld_o,
    output logic cnt_o,
    output logic busy_o,
    output logic done_o,
    output logic accept_o
);

    state_e state_q, state_d;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode; stop overrides every transition and suppresses done
    always_comb begin
        state_d  = state_q;
        ld_o     = 1'b0;
        cnt_o    = 1'b0;
        done_o   = 1'b0;
        accept_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    accept_o = 1'b1;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                ld_o    = 1'b1;
                state_d = S_RUN;
            end
            S_RUN: begin
`ifdef TIMER_CTRL_PAUSE_EN
                if (!pause_i) begin
                    cnt_o = ~tcount_i;
                    if (tcount_i) state_d = S_DONE;
                end
`else
                // Counter holds at all-ones once tcount rises
                cnt_o = ~tcount_i;
                if (tcount_i) state_d = S_DONE;
`endif
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = auto_rl_i ? S_LOAD : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (stop_i) begin
            state_d  = S_IDLE;
            done_o   = 1'b0;
            accept_o = 1'b0;
        end
    end

    assign busy_o = (state_q != S_IDLE);

endmodule

// File: rtl/timer_ctrl_4b.sv
// rtl/timer_ctrl_4b.sv - interval-timer controller top: period latch, lap counter, counter load value (optional pause: TIMER_CTRL_PAUSE_EN)
module timer_ctrl_4b
    import timer_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
)(
    input  logic            clk,
    input  logic            rst,
    timer_ctrl_4b_if.slave  bus
);

    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] laps_q, laps_d;
    logic             accept;
    logic             done;

    timer_ctrl_fsm u_fsm (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (bus.start),
        .stop_i    (bus.stop),
        .auto_rl_i (bus.auto_rl),
        .tcount_i  (bus.tcount),
`ifdef TIMER_CTRL_PAUSE_EN
        .pause_i   (bus.pause),
`endif
        .ld_o      (bus.ld),
        .cnt_o     (bus.cnt),
        .busy_o    (bus.busy),
        .done_o    (done),
        .accept_o  (accept)
    );

    // Period is captured and laps cleared only on an accepted start; laps counts done pulses
    always_comb begin
        period_d = period_q;
        laps_d   = laps_q;
        if (accept) begin
            period_d = bus.period;
            laps_d   = '0;
        end else if (done) begin
            laps_d   = laps_q + 1'b1;
        end
    end

    // Period and lap registers
    always_ff @(posedge clk) begin
        if (rst) begin
            period_q <= '0;
            laps_q   <= '0;
        end else begin
            period_q <= period_d;
            laps_q   <= laps_d;
        end
    end

    // Up-counter starts at 2^WIDTH-1-P so it reaches all-ones after P increments
    assign bus.load_val = ~period_q;
    assign bus.done     = done;
    assign bus.laps     = laps_q;

endmodule
